// File: rtl/multicycle_controller.sv
// Moore control unit for the multicycle stack CPU: one state per cycle, every
// datapath strobe decoded from the current state and forced low while rst is high.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opc,
  output logic [1:0] ALUOP,
  output logic       pcWriteUnCond,
  output logic       pcWriteCond,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       MtoS,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic       ldA,
  output logic       ldB,
  output logic       srcA,
  output logic       srcB,
  output logic       pcSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_POPA   = 4'd2,
    S_LDA    = 4'd3,
    S_POPB   = 4'd4,
    S_LDB    = 4'd5,
    S_EXEC   = 4'd6,
    S_WB     = 4'd7,
    S_MEMRD  = 4'd8,
    S_PUSHM  = 4'd9,
    S_MEMWR  = 4'd10,
    S_JMP    = 4'd11,
    S_TOSRD  = 4'd12,
    S_JZC    = 4'd13,
    S_ILL14  = 4'd14,
    S_ILL15  = 4'd15
  } state_t;

  state_t r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (opc)
            3'b100:  r_state <= S_MEMRD;
            3'b110:  r_state <= S_JMP;
            3'b111:  r_state <= S_TOSRD;
            default: r_state <= S_POPA;
          endcase
        end
        S_POPA:   r_state <= S_LDA;
        S_LDA: begin
          // NOT has a single operand; POP only needs A to store it.
          if (opc == 3'b011)      r_state <= S_EXEC;
          else if (opc == 3'b101) r_state <= S_MEMWR;
          else                    r_state <= S_POPB;
        end
        S_POPB:   r_state <= S_LDB;
        S_LDB:    r_state <= S_EXEC;
        S_EXEC:   r_state <= S_WB;
        S_TOSRD:  r_state <= S_JZC;
        S_MEMRD:  r_state <= S_PUSHM;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  logic [1:0] w_aluop;
  logic       w_pcwu, w_pcwc, w_iord, w_memrd, w_memwr, w_irwr, w_mtos;
  logic       w_push, w_pop, w_tos, w_lda, w_ldb, w_srca, w_srcb, w_pcsrc;

  always_comb begin
    w_aluop = 2'b00;
    w_pcwu  = 1'b0;
    w_pcwc  = 1'b0;
    w_iord  = 1'b0;
    w_memrd = 1'b0;
    w_memwr = 1'b0;
    w_irwr  = 1'b0;
    w_mtos  = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_tos   = 1'b0;
    w_lda   = 1'b0;
    w_ldb   = 1'b0;
    w_srca  = 1'b0;
    w_srcb  = 1'b0;
    w_pcsrc = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memrd = 1'b1;
        w_irwr  = 1'b1;
        w_srca  = 1'b1;
        w_srcb  = 1'b1;
        w_pcwu  = 1'b1;
      end
      S_POPA:  w_pop = 1'b1;
      S_LDA:   w_lda = 1'b1;
      S_POPB:  w_pop = 1'b1;
      S_LDB:   w_ldb = 1'b1;
      S_EXEC:  w_aluop = opc[1:0];
      S_WB:    w_push = 1'b1;
      S_MEMRD: begin
        w_iord  = 1'b1;
        w_memrd = 1'b1;
      end
      S_PUSHM: begin
        w_mtos = 1'b1;
        w_push = 1'b1;
      end
      S_MEMWR: begin
        w_iord  = 1'b1;
        w_memwr = 1'b1;
      end
      S_JMP: begin
        w_pcsrc = 1'b1;
        w_pcwu  = 1'b1;
      end
      S_TOSRD: w_tos = 1'b1;
      S_JZC: begin
        w_pcsrc = 1'b1;
        w_pcwc  = 1'b1;
      end
      default: ;
    endcase
  end

  // Gated with rst so an abandoned instruction drops its strobes without a clock.
  assign ALUOP         = w_aluop & {2{~rst}};
  assign pcWriteUnCond = w_pcwu  & ~rst;
  assign pcWriteCond   = w_pcwc  & ~rst;
  assign IorD          = w_iord  & ~rst;
  assign memRead       = w_memrd & ~rst;
  assign memWrite      = w_memwr & ~rst;
  assign IRWrite       = w_irwr  & ~rst;
  assign MtoS          = w_mtos  & ~rst;
  assign push          = w_push  & ~rst;
  assign pop           = w_pop   & ~rst;
  assign tos           = w_tos   & ~rst;
  assign ldA           = w_lda   & ~rst;
  assign ldB           = w_ldb   & ~rst;
  assign srcA          = w_srca  & ~rst;
  assign srcB          = w_srcb  & ~rst;
  assign pcSrc         = w_pcsrc & ~rst;
  assign state         = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, reset
// corner sequences and a random opcode stream against a rule-based model.
module tb_multicycle_controller;

  logic       clk, rst;
  logic [2:0] opc;
  logic [1:0] ALUOP;
  logic       pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite, MtoS;
  logic       push, pop, tos, ldA, ldB, srcA, srcB, pcSrc;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opc(opc), .ALUOP(ALUOP),
    .pcWriteUnCond(pcWriteUnCond), .pcWriteCond(pcWriteCond), .IorD(IorD),
    .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
    .push(push), .pop(pop), .tos(tos), .ldA(ldA), .ldB(ldB),
    .srcA(srcA), .srcB(srcB), .pcSrc(pcSrc), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit positions of the observed strobe vector.
  localparam int B_PCU = 16, B_PCC = 15, B_IORD = 14, B_MRD = 13, B_MWR = 12;
  localparam int B_IRW = 11, B_MTOS = 10, B_PUSH = 9, B_POP = 8, B_TOS = 7;
  localparam int B_LDA = 6, B_LDB = 5, B_SRCA = 4, B_SRCB = 3, B_PCSRC = 2;

  logic [16:0] w_obs;
  assign w_obs = {pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite, MtoS,
                  push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, ALUOP};

  int n_cmp = 0;
  int n_err = 0;
  bit run_inv = 1'b0;
  logic [16:0] strobe_tab [16];

  typedef struct {
    logic [2:0]  opc;
    int          len;
    logic [31:0] seq;   // state codes, first state in the low nibble
  } vec_t;
  vec_t vecs [8];

  function automatic logic [16:0] exp_strobes(input logic [3:0] st, input logic [2:0] o);
    logic [16:0] e;
    e = strobe_tab[st];
    if (st == 4'd6) e[1:0] = o[1:0];
    return e;
  endfunction

  task automatic check(input string name, input logic [3:0] exp_st, input logic [16:0] exp_sb);
    n_cmp++;
    if (state !== exp_st || w_obs !== exp_sb) begin
      n_err++;
      $display("FAIL %s: got state=%0d strobes=%h, required state=%0d strobes=%h",
               name, state, w_obs, exp_st, exp_sb);
    end
  endtask

  // Entered mid-FETCH; leaves at the negedge of the following FETCH.
  task automatic run_seq(input string name, input logic [2:0] o,
                         input logic [31:0] seq, input int len);
    logic [3:0] st;
    opc = o;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      st = seq[4*k +: 4];
      check(name, st, exp_strobes(st, o));
    end
    @(negedge clk);
  endtask

  // Reference model: the state walk built from the instruction's needs.
  function automatic void model_seq(input logic [2:0] o, output logic [31:0] seq, output int len);
    logic [3:0] q[$];
    q.push_back(4'd0);
    q.push_back(4'd1);
    if (o <= 3'd3 || o == 3'd5) begin q.push_back(4'd2); q.push_back(4'd3); end
    if (o <= 3'd2)              begin q.push_back(4'd4); q.push_back(4'd5); end
    if (o <= 3'd3)              begin q.push_back(4'd6); q.push_back(4'd7); end
    if (o == 3'd4)              begin q.push_back(4'd8); q.push_back(4'd9); end
    if (o == 3'd5)              q.push_back(4'd10);
    if (o == 3'd6)              q.push_back(4'd11);
    if (o == 3'd7)              begin q.push_back(4'd12); q.push_back(4'd13); end
    seq = '0;
    len = q.size();
    for (int i = 0; i < len; i++) seq[4*i +: 4] = q[i];
  endfunction

  always @(negedge clk) begin
    if (run_inv && !rst) begin
      n_cmp++;
      if ((push && pop) || (memRead && memWrite) || (pcWriteUnCond && pcWriteCond)) begin
        n_err++;
        $display("FAIL invariant: state=%0d push=%b pop=%b memRead=%b memWrite=%b pcWU=%b pcWC=%b, required no pair both 1",
                 state, push, pop, memRead, memWrite, pcWriteUnCond, pcWriteCond);
      end
    end
  end

  initial begin
    logic [31:0] rseq;
    int          rlen;
    logic [2:0]  ro;

    for (int s = 0; s < 16; s++) strobe_tab[s] = '0;
    strobe_tab[0][B_MRD] = 1'b1;  strobe_tab[0][B_IRW] = 1'b1;
    strobe_tab[0][B_SRCA] = 1'b1; strobe_tab[0][B_SRCB] = 1'b1;
    strobe_tab[0][B_PCU] = 1'b1;
    strobe_tab[2][B_POP] = 1'b1;
    strobe_tab[3][B_LDA] = 1'b1;
    strobe_tab[4][B_POP] = 1'b1;
    strobe_tab[5][B_LDB] = 1'b1;
    strobe_tab[7][B_PUSH] = 1'b1;
    strobe_tab[8][B_IORD] = 1'b1;  strobe_tab[8][B_MRD] = 1'b1;
    strobe_tab[9][B_MTOS] = 1'b1;  strobe_tab[9][B_PUSH] = 1'b1;
    strobe_tab[10][B_IORD] = 1'b1; strobe_tab[10][B_MWR] = 1'b1;
    strobe_tab[11][B_PCSRC] = 1'b1; strobe_tab[11][B_PCU] = 1'b1;
    strobe_tab[12][B_TOS] = 1'b1;
    strobe_tab[13][B_PCSRC] = 1'b1; strobe_tab[13][B_PCC] = 1'b1;

    vecs[0] = '{3'b000, 8, 32'h7654_3210};
    vecs[1] = '{3'b001, 8, 32'h7654_3210};
    vecs[2] = '{3'b010, 8, 32'h7654_3210};
    vecs[3] = '{3'b011, 6, 32'h0076_3210};
    vecs[4] = '{3'b100, 4, 32'h0000_9810};
    vecs[5] = '{3'b101, 5, 32'h000A_3210};
    vecs[6] = '{3'b110, 3, 32'h0000_0B10};
    vecs[7] = '{3'b111, 4, 32'h0000_DC10};

    rst = 1'b1;
    opc = 3'b000;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 4'd0, 17'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_release_fetch", 4'd0, strobe_tab[0]);
    run_inv = 1'b1;

    foreach (vecs[i]) run_seq($sformatf("vec_opc%0d", vecs[i].opc), vecs[i].opc, vecs[i].seq, vecs[i].len);
    check("back_to_fetch", 4'd0, strobe_tab[0]);

    // Reset in LDB of an ADD: abandon immediately, no push afterwards.
    opc = 3'b000;
    repeat (5) @(negedge clk);
    check("add_reach_ldb", 4'd5, strobe_tab[5]);
    #1 rst = 1'b1;
    #1 check("async_reset_mid_instr", 4'd0, 17'd0);
    @(posedge clk);
    #1 check("reset_held_over_edge", 4'd0, 17'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("clean_fetch_after_abort", 4'd0, strobe_tab[0]);
    run_seq("add_after_abort", 3'b000, 32'h7654_3210, 8);

    for (int n = 0; n < 150; n++) begin
      ro = 3'($urandom_range(0, 7));
      model_seq(ro, rseq, rlen);
      run_seq($sformatf("rand%0d_opc%0d", n, ro), ro, rseq, rlen);
    end
    check("final_fetch", 4'd0, strobe_tab[0]);
    run_inv = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
